// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared state encoding and sizing for the memory arbiter
package memory_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;
  localparam int NUM_PORTS  = 4;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int LAT_W      = 4;
endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rr_picker: round-robin pick of the first active request at or after rr_ptr
module rr_picker
  import memory_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           rr_ptr,
  output logic                 grant_valid,
  output logic [1:0]           grant_idx
);
  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [1:0]             off;
  always_comb begin
    dbl         = {req, req};
    rot         = dbl[rr_ptr +: NUM_PORTS];
    off         = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    grant_idx   = rr_ptr + off;
    grant_valid = |req;
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one memory command channel among four requesters
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] address,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [1:0]                  mem_sel,
  output logic                        mem_en,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);
  state_t           state;
  logic [1:0]       rr_ptr;
  logic [LAT_W-1:0] lat_cnt;
  logic             rd_op;
  logic             grant_valid;
  logic [1:0]       grant_idx;

  rr_picker u_pick (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign busy = state != IDLE;

  // rd_op remembers the direction after the strobes drop, so the ACK path knows whether to capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lat_cnt     <= '0;
      rd_op       <= 1'b0;
      ack         <= '0;
      rdata       <= '0;
      mem_sel     <= '0;
      mem_en      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          mem_sel     <= grant_idx;
          mem_write   <= we[grant_idx];
          mem_read    <= ~we[grant_idx];
          rd_op       <= ~we[grant_idx];
          mem_address <= address[grant_idx*ADDR_W +: ADDR_W];
          mem_wdata   <= wdata[grant_idx*DATA_W +: DATA_W];
          mem_en      <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          lat_cnt   <= LAT_W'(MEM_LATENCY);
          state     <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            if (rd_op) rdata <= mem_rdata;
            ack   <= NUM_PORTS'(1) << mem_sel;
            state <= ACK;
          end
        end
        ACK: begin
          ack    <= '0;
          rr_ptr <= mem_sel + 2'd1;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized requesters checked against a transaction-timeline reference model
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;
  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset, busy, mem_en, mem_read, mem_write;
  logic [3:0] req, we, ack;
  logic [4*AW-1:0] address;
  logic [4*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [1:0] mem_sel;
  logic [AW-1:0] mem_address;

  logic reset4, busy4, mem_en4, mem_read4, mem_write4;
  logic [3:0] req4, ack4;
  logic [4*AW-1:0] address4;
  logic [4*DW-1:0] wdata4;
  logic [DW-1:0] rdata4, mem_wdata4, mem_rdata4;
  logic [1:0] mem_sel4;
  logic [AW-1:0] mem_address4;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_sel(mem_sel), .mem_en(mem_en),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset4), .req(req4), .we(4'b0000), .address(address4), .wdata(wdata4),
    .ack(ack4), .rdata(rdata4), .busy(busy4), .mem_sel(mem_sel4), .mem_en(mem_en4),
    .mem_read(mem_read4), .mem_write(mem_write4), .mem_address(mem_address4),
    .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
  );

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic set_port(input int i);
    we[i] = 1'($urandom);
    address[i*AW +: AW] = AW'($urandom);
    wdata[i*DW +: DW] = DW'($urandom);
  endtask

  // reference: t counts cycles since the grant edge (0 = idle, 1 = issue, 2+LAT = ack)
  int t = 0, g = 0, ptr = 0, rd_at = -1;
  bit mw, rst_chk, reset_done, done4;
  logic [AW-1:0] ma;
  logic [DW-1:0] md, rd_val, exp_rdata;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  initial begin
    reset = 1'b1; req = '0; we = '0; address = '0; wdata = '0; mem_rdata = '0;
    exp_rdata = '0;
    for (int k = 0; k < (1 << AW); k++) mem[k] = DW'($urandom);
    repeat (2) @(posedge clk);
    rst_chk = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (mem_en && mem_write) mem[mem_address] = mem_wdata;
      if (mem_en && mem_read) begin
        rd_at = cyc + LAT;
        rd_val = mem[mem_address];
      end
      mem_rdata = (cyc == rd_at) ? rd_val : DW'($urandom);
      check("busy", busy, t != 0);
      check("ack", ack, (t == 2 + LAT) ? (32'd1 << g) : 32'd0);
      check("rdata", rdata, exp_rdata);
      check("mem_en", mem_en, t == 1);
      if (t == 1) begin
        check("mem_read", mem_read, !mw);
        check("mem_write", mem_write, mw);
        check("mem_wdata", mem_wdata, md);
      end else check("strobes", {mem_read, mem_write}, 0);
      if (t >= 1) begin
        check("mem_sel", mem_sel, g);
        check("mem_address", mem_address, ma);
      end
      if (rst_chk) begin
        check("rst_sel", mem_sel, 0);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_chk = 1'b0;
        reset = 1'b0;
      end
      if (!reset_done && cyc >= 700 && t >= 2 && t <= 1 + LAT && !mw) begin
        reset = 1'b1;
        reset_done = 1'b1;
      end
      if (cyc == 0) begin
        req[0] = 1'b1; we[0] = 1'b1; address[0 +: AW] = 7'd10; wdata[0 +: DW] = 8'd10;
      end
      for (int i = 0; i < 4; i++) begin
        bit acked, granted;
        acked = (t == 2 + LAT) && g == i;
        granted = (t >= 1) && (t < 2 + LAT) && g == i;
        if (cyc < 15) begin
          if (acked) begin
            req[i] = 1'b0;
            if (i == 0) begin
              req[1] = 1'b1; we[1] = 1'b0; address[AW +: AW] = 7'd10;
            end
          end else if (granted && i == 1 && t == 1) req[1] = 1'b0;
        end else if (cyc < 60) begin
          req[i] = 1'b1;
          if (granted || acked) set_port(i);
        end else if (cyc < 100) begin
          if (i < 2) req[i] = 1'b0;
          else if (i == 2) begin
            req[2] = 1'b1;
            if (acked) set_port(2);
          end else if (cyc == 62) begin
            req[3] = 1'b1; set_port(3);
          end else if (acked) req[3] = 1'b0;
        end else if (granted) begin
          set_port(i);
          if ($urandom_range(9) == 0) req[i] = 1'b0;
        end else if (acked) begin
          if ($urandom_range(3) == 0) set_port(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          set_port(i);
        end
      end
      @(posedge clk);
      if (reset) begin
        t = 0; ptr = 0; exp_rdata = '0; rst_chk = 1'b1;
      end else if (t == 0) begin
        if (req != 0) begin
          g = first_from(req, ptr);
          mw = we[g]; ma = address[g*AW +: AW]; md = wdata[g*DW +: DW];
          t = 1;
        end
      end else if (t == 2 + LAT) begin
        ptr = (g + 1) % 4;
        t = 0;
      end else begin
        t++;
        if (t == 2 + LAT && !mw) exp_rdata = mem[ma];
      end
    end
    @(negedge clk);
    check("latency4_done", done4, 1);
    check("reset_exercised", reset_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // MEM_LATENCY=4: one read of 0x7F by requester 2, memory answers 4 cycles after the command
  initial begin
    int n_issue;
    reset4 = 1'b1; req4 = '0; address4 = '0; wdata4 = '0; mem_rdata4 = '0;
    address4[2*AW +: AW] = 7'h7F;
    n_issue = 100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset4 = 1'b0;
    req4 = 4'b0100;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (mem_en4) begin
        n_issue = n;
        check("l4_sel", mem_sel4, 2);
        check("l4_read", {mem_read4, mem_write4}, 2'b10);
        check("l4_wdata", mem_wdata4, 0);
      end
      mem_rdata4 = (n == n_issue + 4) ? 8'hA5 : 8'h5A ^ DW'(n);
      check("l4_ack", ack4, (n == 6) ? 4'b0100 : 4'b0000);
      check("l4_busy", busy4, n <= 6);
      if (n <= 6) check("l4_addr", mem_address4, 7'h7F);
      if (ack4[2]) req4 = 4'b0000;
    end
    check("l4_issue_cycle", n_issue, 1);
    check("l4_rdata", rdata4, 8'hA5);
    done4 = 1'b1;
  end
endmodule
